crc8_rx_framer: RTL and testbench

- Receive-side framing stage directly upstream of the 8-bit serial CRC checker.
- Accepts a bit-serial frame (payload bytes plus one trailing CRC byte, MSB first) and drives the checker's clear/data/enable.
- Deserialises the payload into bytes and streams them downstream on a valid/ready port, dropping the CRC byte.
- At end of frame, samples the checker's remainder and reports good/bad CRC plus framing errors.

---
 rtl/crc8_rx_framer_pkg.sv | 30 +++
 rtl/crc8_rx_framer_if.sv | 10 +
 rtl/crc8_serial_checker.sv | 34 +++
 rtl/crc8_rx_framer.sv | 213 +++++++++++++++++++++
 tb/tb_crc8_rx_framer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/crc8_rx_framer_pkg.sv
// rtl/crc8_rx_framer_pkg.sv - shared types and constants for the CRC-8 receive framer
// Holds the FSM encoding, error codes and the serial CRC-8 step (x^8+x^2+x+1).
package crc8_rx_framer_pkg;

  localparam int CRC_W = 8;
  localparam logic [CRC_W-1:0] CRC_GOOD_RESIDUE = 8'h00;
  localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_ALIGN = 3'd1,
    ERR_SHORT = 3'd2,
    ERR_LONG  = 3'd3,
    ERR_SOF   = 3'd4,
    ERR_OVF   = 3'd5
  } err_e;

  function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] c, input logic b);
    logic fb;
    fb = c[CRC_W-1] ^ b;
    return {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/crc8_rx_framer_if.sv
// rtl/crc8_rx_framer_if.sv - downstream payload byte stream of the receive framer
interface crc8_rx_framer_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/crc8_serial_checker.sv
// rtl/crc8_serial_checker.sv - bit-serial CRC-8 checker, init 0, clear has priority over enable
module crc8_serial_checker
  import crc8_rx_framer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             data,
  input  logic             enable,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (enable) begin
      crc_d = crc8_step(crc_q, data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/crc8_rx_framer.sv
// rtl/crc8_rx_framer.sv - serial frame deserialiser feeding the CRC-8 checker, drops the CRC byte
// Optional frame length report enabled by defining RX_LEN_REPORT_EN.
module crc8_rx_framer
  import crc8_rx_framer_pkg::*;
#(
  parameter int MAX_BYTES = 64,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic             rx_bit,
  input  logic             rx_sof,
  input  logic             rx_eof,
  output logic             crc_clear,
  output logic             crc_data,
  output logic             crc_enable,
  input  logic [CRC_W-1:0] crc_in,
  crc8_rx_framer_if.master m_if,
  output logic             frame_done,
  output logic             crc_ok,
  output logic             frame_err,
  output logic [2:0]       err_code
`ifdef RX_LEN_REPORT_EN
  ,
  output logic [CNT_W-1:0] frame_len
`endif
);

  localparam logic [CNT_W:0] MAX_CNT = (CNT_W+1)'(MAX_BYTES);
  localparam logic [CNT_W:0] MIN_CNT = (CNT_W+1)'(2);

  state_e           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [6:0]       shift_q, shift_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]       pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  err_e             err_q, err_d;

  logic [3:0]       bit_inc;
  logic [CNT_W:0]   byte_inc;
  logic [7:0]       new_byte;
  logic             out_busy;
  logic             abort;
  err_e             abort_code;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    m_valid_d  = m_valid_q && !m_if.m_ready;
    err_d      = err_q;
    abort      = 1'b0;
    abort_code = ERR_NONE;
    bit_inc    = bit_cnt_q + 4'd1;
    byte_inc   = {1'b0, byte_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    new_byte   = {shift_q, rx_bit};
    out_busy   = m_valid_q && !m_if.m_ready;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && rx_sof) begin
          shift_d    = {6'd0, rx_bit};
          bit_cnt_d  = 4'd1;
          byte_cnt_d = '0;
          pend_vld_d = 1'b0;
          err_d      = ERR_NONE;
          if (rx_eof) begin
            abort      = 1'b1;
            abort_code = ERR_ALIGN;
          end else begin
            state_d = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (rx_valid) begin
          if (rx_sof) begin
            abort      = 1'b1;
            abort_code = ERR_SOF;
          end else begin
            shift_d   = {shift_q[5:0], rx_bit};
            bit_cnt_d = bit_inc;
            if (bit_inc == 4'd8) begin
              bit_cnt_d  = 4'd0;
              byte_cnt_d = byte_inc[CNT_W-1:0];
              if (byte_inc > MAX_CNT) begin
                abort      = 1'b1;
                abort_code = ERR_LONG;
              end else if (rx_eof) begin
                if (byte_inc < MIN_CNT) begin
                  abort      = 1'b1;
                  abort_code = ERR_SHORT;
                end else if (out_busy) begin
                  abort      = 1'b1;
                  abort_code = ERR_OVF;
                end else begin
                  // The completing byte is the CRC; only the pending payload byte leaves.
                  m_data_d   = pend_q;
                  m_valid_d  = 1'b1;
                  m_last_d   = 1'b1;
                  pend_vld_d = 1'b0;
                  err_d      = ERR_NONE;
                  state_d    = ST_DONE;
                end
              end else if (pend_vld_q && out_busy) begin
                abort      = 1'b1;
                abort_code = ERR_OVF;
              end else begin
                if (pend_vld_q) begin
                  m_data_d  = pend_q;
                  m_valid_d = 1'b1;
                  m_last_d  = 1'b0;
                end
                pend_d     = new_byte;
                pend_vld_d = 1'b1;
              end
            end else if (rx_eof) begin
              abort      = 1'b1;
              abort_code = ERR_ALIGN;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d    = ST_DONE;
      pend_vld_d = 1'b0;
      err_d      = abort_code;
    end
    if (!m_valid_d) begin
      m_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      err_q      <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      err_q      <= err_d;
    end
  end

`ifdef RX_LEN_REPORT_EN
  logic [CNT_W-1:0] len_q, len_d;

  // Good frames report payload bytes (the CRC byte excluded); errors report bytes seen.
  always_comb begin
    len_d = len_q;
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      len_d = (err_d == ERR_NONE) ? byte_cnt_q : byte_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
    end else begin
      len_q <= len_d;
    end
  end

  assign frame_len = len_q;
`endif

  assign m_if.m_data  = m_data_q;
  assign m_if.m_valid = m_valid_q;
  assign m_if.m_last  = m_last_q;

  assign frame_done = (state_q == ST_DONE);
  assign frame_err  = frame_done && (err_q != ERR_NONE);
  assign err_code   = frame_done ? err_q : ERR_NONE;
  // The checker already holds the eof bit here, so its remainder is final.
  assign crc_ok     = frame_done && !frame_err && (crc_in == CRC_GOOD_RESIDUE);
  assign crc_clear  = frame_done;
  assign crc_data   = rx_bit;
  assign crc_enable = rx_valid && (((state_q == ST_IDLE) && rx_sof) || (state_q == ST_RECV));

endmodule

// File: tb/tb_crc8_rx_framer.sv
// tb/tb_crc8_rx_framer.sv - randomized bench for crc8_rx_framer with the serial CRC-8 checker
// Frame outcomes are predicted from bit positions of eof/sof and byte-wise CRC arithmetic.
module tb_crc8_rx_framer;
  localparam int MAX_BYTES = 64;
  localparam int CNT_W     = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0, rx_bit = 1'b0, rx_sof = 1'b0, rx_eof = 1'b0;
  logic       crc_clear, crc_data, crc_enable;
  logic [7:0] crc_in;
  logic       frame_done, crc_ok, frame_err;
  logic [2:0] err_code;
`ifdef RX_LEN_REPORT_EN
  logic [CNT_W-1:0] frame_len;
`endif

  crc8_rx_framer_if bus();

  crc8_rx_framer #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_bit(rx_bit), .rx_sof(rx_sof),
    .rx_eof(rx_eof), .crc_clear(crc_clear), .crc_data(crc_data), .crc_enable(crc_enable),
    .crc_in(crc_in), .m_if(bus.master), .frame_done(frame_done), .crc_ok(crc_ok),
    .frame_err(frame_err), .err_code(err_code)
`ifdef RX_LEN_REPORT_EN
    , .frame_len(frame_len)
`endif
  );

  crc8_serial_checker u_chk (
    .clk(clk), .rst_n(rst_n), .clear(crc_clear), .data(crc_data), .enable(crc_enable), .crc(crc_in)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic [7:0] got_data[$];
  logic       got_last[$];
  logic [2:0] got_err;
  logic       got_ok, got_ferr;
  int         got_len;
  logic [7:0] frame_bytes[$];
  bit         use_gaps = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.m_valid && bus.m_ready) begin
        got_data.push_back(bus.m_data);
        got_last.push_back(bus.m_last);
      end
      if (frame_done) begin
        done_cnt++;
        got_err  = err_code;
        got_ok   = crc_ok;
        got_ferr = frame_err;
`ifdef RX_LEN_REPORT_EN
        got_len  = int'(frame_len);
`else
        got_len  = 0;
`endif
      end
    end
  end

  function automatic logic [7:0] crc_bytes(input int n);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      c = c ^ frame_bytes[i];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  task automatic build(input int npay, input logic [7:0] flip);
    logic [7:0] c;
    frame_bytes.delete();
    for (int i = 0; i < npay; i++) frame_bytes.push_back(8'($urandom));
    c = crc_bytes(npay);
    frame_bytes.push_back(c ^ flip);
  endtask

  task automatic drive_bit(input logic b, input logic s, input logic e);
    rx_valid = 1'b1; rx_bit = b; rx_sof = s; rx_eof = e;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_bit = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
    if (use_gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
  endtask

  // e: index of the eof bit, s: index of a stray sof bit (or -1), r0: m_ready held low.
  task automatic run_frame(input string tag, input int e, input int s, input bit r0);
    int start, t, kind, long_t, del, len, elen;
    logic [7:0] cur;
    logic ok;
    logic [2:0] err;
    start = done_cnt;
    got_data.delete(); got_last.delete();
    bus.m_ready = !r0;
    for (int i = 0; i <= e; i++) begin
      cur = frame_bytes[i / 8];
      drive_bit(cur[7 - (i % 8)], (i == 0) || (i == s), i == e);
    end
    for (int k = 0; k < 20 && done_cnt == start; k++) begin @(posedge clk); #1; end
    bus.m_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end

    long_t = 8 * (MAX_BYTES + 1) - 1;
    t = e; kind = 0;
    if (r0 && 23 <= t) begin t = 23; kind = 3; end
    if (long_t <= t) begin t = long_t; kind = 2; end
    if (s > 0 && s <= t) begin t = s; kind = 1; end
    ok = 1'b0;
    case (kind)
      1: begin err = 3'd4; del = (t / 8 > 0) ? t / 8 - 1 : 0; len = t / 8; end
      2: begin err = 3'd3; del = MAX_BYTES - 1; len = MAX_BYTES + 1; end
      3: begin err = 3'd5; del = 1; len = 3; end
      default: begin
        if (((t + 1) % 8) != 0) begin
          err = 3'd1; len = (t + 1) / 8; del = (len > 0) ? len - 1 : 0;
        end else if ((t + 1) / 8 < 2) begin
          err = 3'd2; del = 0; len = 1;
        end else begin
          err = 3'd0; del = (t + 1) / 8 - 1; len = del;
          ok = (crc_bytes(del + 1) == 8'h00);
        end
      end
    endcase
    elen = len;

    check_eq({tag, ".done_count"}, 32'(done_cnt - start), 32'd1);
    check_eq({tag, ".err_code"}, 32'(got_err), 32'(err));
    check_eq({tag, ".frame_err"}, 32'(got_ferr), 32'(err != 3'd0));
    check_eq({tag, ".crc_ok"}, 32'(got_ok), 32'(ok));
`ifdef RX_LEN_REPORT_EN
    check_eq({tag, ".frame_len"}, 32'(got_len), 32'(elen));
`endif
    check_eq({tag, ".byte_count"}, 32'(got_data.size()), 32'(del));
    for (int i = 0; i < del && i < got_data.size(); i++) begin
      check_eq($sformatf("%s.byte%0d", tag, i), 32'(got_data[i]), 32'(frame_bytes[i]));
      check_eq($sformatf("%s.last%0d", tag, i), 32'(got_last[i]), 32'((err == 3'd0) && (i == del - 1)));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int npay, kind, e, s;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.m_valid", 32'(bus.m_valid), 32'd0);
    check_eq("rst.m_data", 32'(bus.m_data), 32'd0);
    check_eq("rst.m_last", 32'(bus.m_last), 32'd0);
    check_eq("rst.frame_done", 32'(frame_done), 32'd0);
    check_eq("rst.crc_clear", 32'(crc_clear), 32'd0);
    check_eq("rst.err_code", 32'(err_code), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    frame_bytes.delete();
    frame_bytes.push_back(8'h31); frame_bytes.push_back(8'h32);
    frame_bytes.push_back(crc_bytes(2));
    run_frame("good12", 23, -1, 1'b0);
    frame_bytes[2] = frame_bytes[2] ^ 8'h01;
    run_frame("badcrc", 23, -1, 1'b0);
    build(2, 8'h00);
    run_frame("eof13", 12, -1, 1'b0);
    build(3, 8'h00);
    run_frame("after_align", 31, -1, 1'b0);
    build(0, 8'h00);
    run_frame("short", 7, -1, 1'b0);
    build(MAX_BYTES, 8'h00);
    run_frame("long", 8 * (MAX_BYTES + 1) - 1, -1, 1'b0);
    build(4, 8'h00);
    run_frame("sof20", 39, 19, 1'b0);
    build(4, 8'h00);
    run_frame("ovf", 39, -1, 1'b1);
    build(5, 8'h00);
    run_frame("len5", 47, -1, 1'b0);

    build(3, 8'h00);
    bus.m_ready = 1'b0;
    for (int i = 0; i < 20; i++) drive_bit(frame_bytes[i / 8][7 - (i % 8)], i == 0, 1'b0);
    check_eq("rstmid.pre_valid", 32'(bus.m_valid), 32'd1);
    e = done_cnt;
    rst_n = 1'b0;
    #1;
    check_eq("rstmid.m_valid", 32'(bus.m_valid), 32'd0);
    check_eq("rstmid.m_data", 32'(bus.m_data), 32'd0);
    check_eq("rstmid.crc_in", 32'(crc_in), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check_eq("rstmid.no_done", 32'(done_cnt - e), 32'd0);
    build(2, 8'h00);
    run_frame("after_rst", 23, -1, 1'b0);

    use_gaps = 1'b1;
    for (int f = 0; f < 16; f++) begin
      npay = $urandom_range(1, 8);
      kind = $urandom_range(0, 4);
      e = 8 * (npay + 1) - 1;
      s = -1;
      case (kind)
        1: build(npay, 8'(1 << $urandom_range(0, 7)));
        2: begin
          build(npay, 8'h00);
          e = $urandom_range(1, 8 * (npay + 1) - 2);
          if (((e + 1) % 8) == 0) e = e - 1;
        end
        3: begin build(npay, 8'h00); s = $urandom_range(1, e - 1); end
        4: begin npay = $urandom_range(3, 8); build(npay, 8'h00); e = 8 * (npay + 1) - 1; end
        default: build(npay, 8'h00);
      endcase
      run_frame($sformatf("rnd%0d_k%0d", f, kind), e, s, kind == 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
